renew_dispatch_queue: RTL and testbench
=======================================

Name: renew_dispatch_queue

Overview:
- Upstream feeder of the registers management stage in the dual-issue microcontroller.
- Buffers decoded instructions from the multi-processor manager's fetch/decode path in a small FIFO.
- Checks the head entry against the in-flight register table for RAW/WAW hazards.
- Selects a free processor (1 preferred, then 2), then emits a single-cycle boot_renew pulse plus register_num and the instruction word to that processor; at most one dispatch per cycle.

Parameters:
REGISTER_AMOUNT, 32, number of architectural registers
REG_CTN_WIDTH, 5, register index width; must equal clog2(REGISTER_AMOUNT)
INSTR_WIDTH, 32, instruction word width
FIFO_DEPTH, 4, queue entries; power of two, minimum 2
GUARD_CYCLES, 2, cycles a just-dispatched processor is blocked before its idle input is trusted again

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  upstream has an instruction
req_ready  out  1  queue can accept; equals not full
req_instr  in  INSTR_WIDTH  instruction word
req_rd  in  REG_CTN_WIDTH  destination register
req_rs1  in  REG_CTN_WIDTH  source register 1
req_rs2  in  REG_CTN_WIDTH  source register 2
processing_register_table  in  REGISTER_AMOUNT  bit i=1: register i in flight (index 0 = MSB, [0:N-1])
processor_idle_1  in  1  processor 1 idle
processor_idle_2  in  1  processor 2 idle
sync_hold  in  1  suppress dispatch (manager synchronization phase)
boot_renew_register_1  out  1  one-cycle dispatch pulse to processor 1
boot_renew_register_2  out  1  one-cycle dispatch pulse to processor 2
register_num  out  REG_CTN_WIDTH  rd of dispatched entry; valid with either boot pulse
instr_out  out  INSTR_WIDTH  instruction of dispatched entry; valid with either boot pulse
queue_count  out  clog2(FIFO_DEPTH)+1  current occupancy
queue_empty  out  1  occupancy == 0

Behaviour:
- Reset values: all outputs registered, 0; req_ready=1 and queue_empty=1 after reset. Pointers, count and guard counters cleared. Reset mid-operation discards all queued entries and aborts any pending pulse.
- Enqueue: on req_valid & req_ready. Entry = {instr, rd, rs1, rs2}. A write into an empty queue is not dispatchable in the same cycle; minimum latency from req accept to boot pulse is 1 cycle.
- Hazard: head blocked if table bit is set for rd, rs1 or rs2. Index 0 is ignored for all three. Index 1 (ra) is ignored for rs1/rs2 only.
- Blackout: the cycle immediately after any boot pulse is never a dispatch cycle, because the table updates one cycle late.
- Processor availability:
  - Processor k is available when guard_k == 0 and processor_idle_k == 1.
  - On dispatch to k, guard_k loads GUARD_CYCLES and decrements each cycle to 0.
- Dispatch condition: not empty, no hazard, no blackout, sync_hold == 0, and at least one processor available.
  - Choose processor 1 if available, else processor 2.
  - In the same registered cycle: exactly one boot pulse high, register_num = head.rd, instr_out = head.instr; head pops.
  - boot_renew_register_1 and boot_renew_register_2 are never both high.
- Simultaneous enqueue and pop: count unchanged. Enqueue while full is impossible because req_ready=0. Pointers wrap modulo FIFO_DEPTH.
- In-order only: a blocked head blocks younger entries.
- Outputs outside pulse cycles: register_num and instr_out hold their last value; boot pulses are 0.
- sync_hold high while the head is ready: no pulse is produced and the queue is not modified, but enqueue continues.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- When defined, adds three outputs:
  - stall_hazard_cnt (16 bit): increments each cycle the queue is non-empty and the head is hazard-blocked.
  - stall_busy_cnt (16 bit): increments each cycle the queue is non-empty, the head is not hazard-blocked, and no processor is available.
  - dispatch_cnt (16 bit): increments per boot pulse.
- All three counters saturate at 0xFFFF and reset to 0.
- When not defined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Basic dispatch: reset; both idle; enqueue rd=5, rs1=2, rs2=3, empty table → one cycle later boot_renew_register_1=1, register_num=5, instr_out matches; queue_empty=1.
- Back-to-back alternation: enqueue rd=4, 6, 7 on consecutive cycles, both idle → pulses on P1 (rd4), P2 (rd6) two cycles later (blackout), P1 (rd7) after guard_1 expires; never two pulses in one cycle.
- Hazard stall: table bit 6 set; head rs1=6 → no pulse; clear bit 6 → pulse next cycle. Entry rs1=0 with bit 0 set → not blocked.
- Full queue: processors busy, enqueue 4 entries → req_ready=0, queue_count=4; a fifth req_valid is not accepted; processor 1 goes idle → one pop, req_ready returns to 1, order preserved.
- sync_hold and reset: head ready, sync_hold=1 for 3 cycles → no pulse; release → pulse. Assert rst_n=0 with 3 entries queued → count=0, no pulses, req_ready=1.

Source files
------------

// File: rtl/renew_dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions, stalls the head on register hazards and
// issues it to processor 1 or 2. Optional stall/dispatch counters are enabled by DISPATCH_STATS_EN.
module renew_dispatch_queue #(
  parameter int unsigned REGISTER_AMOUNT = 32,
  parameter int unsigned REG_CTN_WIDTH   = 5,
  parameter int unsigned INSTR_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GUARD_CYCLES    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [INSTR_WIDTH-1:0]       req_instr,
  input  logic [REG_CTN_WIDTH-1:0]     req_rd,
  input  logic [REG_CTN_WIDTH-1:0]     req_rs1,
  input  logic [REG_CTN_WIDTH-1:0]     req_rs2,
  input  logic [0:REGISTER_AMOUNT-1]   processing_register_table,
  input  logic                         processor_idle_1,
  input  logic                         processor_idle_2,
  input  logic                         sync_hold,
  output logic                         boot_renew_register_1,
  output logic                         boot_renew_register_2,
  output logic [REG_CTN_WIDTH-1:0]     register_num,
  output logic [INSTR_WIDTH-1:0]       instr_out,
  output logic [$clog2(FIFO_DEPTH):0]  queue_count,
`ifdef DISPATCH_STATS_EN
  output logic                         queue_empty,
  output logic [15:0]                  stall_hazard_cnt,
  output logic [15:0]                  stall_busy_cnt,
  output logic [15:0]                  dispatch_cnt
`else
  output logic                         queue_empty
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GRD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  logic [INSTR_WIDTH-1:0]   instr_mem [FIFO_DEPTH];
  logic [REG_CTN_WIDTH-1:0] rd_mem    [FIFO_DEPTH];
  logic [REG_CTN_WIDTH-1:0] rs1_mem   [FIFO_DEPTH];
  logic [REG_CTN_WIDTH-1:0] rs2_mem   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GRD_W-1:0] guard1_q, guard2_q, guard1_d, guard2_d;

  logic [INSTR_WIDTH-1:0]   head_instr;
  logic [REG_CTN_WIDTH-1:0] head_rd, head_rs1, head_rs2;
  logic empty, full, push, pop;
  logic hazard, blackout, avail1, avail2, dispatch;

  assign head_instr = instr_mem[rd_ptr_q];
  assign head_rd    = rd_mem[rd_ptr_q];
  assign head_rs1   = rs1_mem[rd_ptr_q];
  assign head_rs2   = rs2_mem[rd_ptr_q];

  assign queue_count = count_q;
  assign queue_empty = empty;
  assign req_ready   = ~full;

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == CNT_W'(FIFO_DEPTH));
    push   = req_valid & ~full;
    // x0 is never tracked; ra is only tracked as a destination.
    hazard = ((head_rd  != '0) && processing_register_table[head_rd]) ||
             ((head_rs1 >  REG_CTN_WIDTH'(1)) && processing_register_table[head_rs1]) ||
             ((head_rs2 >  REG_CTN_WIDTH'(1)) && processing_register_table[head_rs2]);
    // The in-flight table lags a dispatch by one cycle, so skip the cycle after any pulse.
    blackout = boot_renew_register_1 | boot_renew_register_2;
    avail1   = (guard1_q == '0) & processor_idle_1;
    avail2   = (guard2_q == '0) & processor_idle_2;
    dispatch = ~empty & ~hazard & ~blackout & ~sync_hold & (avail1 | avail2);
    pop      = dispatch;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    guard1_d = (guard1_q != '0) ? guard1_q - GRD_W'(1) : guard1_q;
    guard2_d = (guard2_q != '0) ? guard2_q - GRD_W'(1) : guard2_q;
    if (dispatch && avail1) begin
      guard1_d = GRD_W'(GUARD_CYCLES);
    end else if (dispatch) begin
      guard2_d = GRD_W'(GUARD_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= req_instr;
      rd_mem[wr_ptr_q]    <= req_rd;
      rs1_mem[wr_ptr_q]   <= req_rs1;
      rs2_mem[wr_ptr_q]   <= req_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q              <= '0;
      rd_ptr_q              <= '0;
      count_q               <= '0;
      guard1_q              <= '0;
      guard2_q              <= '0;
      boot_renew_register_1 <= 1'b0;
      boot_renew_register_2 <= 1'b0;
      register_num          <= '0;
      instr_out             <= '0;
    end else begin
      count_q               <= count_d;
      guard1_q              <= guard1_d;
      guard2_q              <= guard2_d;
      boot_renew_register_1 <= dispatch & avail1;
      boot_renew_register_2 <= dispatch & ~avail1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        register_num <= head_rd;
        instr_out    <= head_instr;
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_hazard_cnt <= '0;
      stall_busy_cnt   <= '0;
      dispatch_cnt     <= '0;
    end else begin
      if (!empty && hazard && stall_hazard_cnt != 16'hFFFF) begin
        stall_hazard_cnt <= stall_hazard_cnt + 16'd1;
      end
      if (!empty && !hazard && !(avail1 || avail2) && stall_busy_cnt != 16'hFFFF) begin
        stall_busy_cnt <= stall_busy_cnt + 16'd1;
      end
      if (dispatch && dispatch_cnt != 16'hFFFF) begin
        dispatch_cnt <= dispatch_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_renew_dispatch_queue.sv
// Directed and random stimulus for renew_dispatch_queue, checked against a queue-based model.
module tb_renew_dispatch_queue;

  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned GUARD_CYCLES = 2;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [0:31] tbl;
  logic        idle1, idle2, sync_hold;
  logic        boot1, boot2;
  logic [4:0]  register_num;
  logic [31:0] instr_out;
  logic [2:0]  queue_count;
  logic        queue_empty;
`ifdef DISPATCH_STATS_EN
  logic [15:0] stall_hazard_cnt, stall_busy_cnt, dispatch_cnt;
  int          m_hc, m_bc, m_dc;
`endif

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  int   m_g1, m_g2;
  bit   m_p1, m_p2;
  logic [4:0]  m_reg;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  renew_dispatch_queue dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_instr                 (req_instr),
    .req_rd                    (req_rd),
    .req_rs1                   (req_rs1),
    .req_rs2                   (req_rs2),
    .processing_register_table (tbl),
    .processor_idle_1          (idle1),
    .processor_idle_2          (idle2),
    .sync_hold                 (sync_hold),
    .boot_renew_register_1     (boot1),
    .boot_renew_register_2     (boot2),
    .register_num              (register_num),
    .instr_out                 (instr_out),
    .queue_count               (queue_count),
    .queue_empty               (queue_empty)
`ifdef DISPATCH_STATS_EN
    , .stall_hazard_cnt        (stall_hazard_cnt)
    , .stall_busy_cnt          (stall_busy_cnt)
    , .dispatch_cnt            (dispatch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("boot1", 32'(boot1), 32'(m_p1));
    check("boot2", 32'(boot2), 32'(m_p2));
    check("no_double_pulse", 32'(boot1 & boot2), 32'd0);
    check("register_num", 32'(register_num), 32'(m_reg));
    check("instr_out", instr_out, m_instr);
    check("queue_count", 32'(queue_count), 32'(mq.size()));
    check("queue_empty", 32'(queue_empty), 32'(mq.size() == 0));
    check("req_ready", 32'(req_ready), 32'(mq.size() < FIFO_DEPTH));
`ifdef DISPATCH_STATS_EN
    check("stall_hazard_cnt", 32'(stall_hazard_cnt), 32'(m_hc));
    check("stall_busy_cnt", 32'(stall_busy_cnt), 32'(m_bc));
    check("dispatch_cnt", 32'(dispatch_cnt), 32'(m_dc));
`endif
  endtask

  // One clock: evaluate the dispatch rules on pre-edge inputs, advance the model, compare.
  task automatic tick();
    bit   nonempty, hz, bo, a1, a2, disp, push;
    ent_t h, n;
    nonempty = (mq.size() != 0);
    push     = req_valid && (mq.size() < FIFO_DEPTH);
    n        = '{req_instr, req_rd, req_rs1, req_rs2};
    a1       = (m_g1 == 0) && idle1;
    a2       = (m_g2 == 0) && idle2;
    bo       = m_p1 || m_p2;
    hz       = 1'b0;
    h        = '{32'd0, 5'd0, 5'd0, 5'd0};
    if (nonempty) begin
      h  = mq[0];
      hz = (h.rd != 0 && tbl[h.rd]) || (h.rs1 > 1 && tbl[h.rs1]) || (h.rs2 > 1 && tbl[h.rs2]);
    end
    disp = nonempty && !hz && !bo && !sync_hold && (a1 || a2);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      m_g1 = 0; m_g2 = 0; m_p1 = 0; m_p2 = 0; m_reg = '0; m_instr = '0;
`ifdef DISPATCH_STATS_EN
      m_hc = 0; m_bc = 0; m_dc = 0;
`endif
    end else begin
`ifdef DISPATCH_STATS_EN
      if (nonempty && hz && m_hc < 16'hFFFF) m_hc++;
      if (nonempty && !hz && !(a1 || a2) && m_bc < 16'hFFFF) m_bc++;
      if (disp && m_dc < 16'hFFFF) m_dc++;
`endif
      if (disp && a1) m_g1 = GUARD_CYCLES; else if (m_g1 > 0) m_g1--;
      if (disp && !a1) m_g2 = GUARD_CYCLES; else if (m_g2 > 0) m_g2--;
      m_p1 = disp && a1;
      m_p2 = disp && !a1;
      if (disp) begin
        m_reg   = h.rd;
        m_instr = h.instr;
        void'(mq.pop_front());
      end
      if (push) mq.push_back(n);
    end
    compare_all();
  endtask

  task automatic set_req(input logic v, input logic [31:0] ins, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
    req_valid = v; req_instr = ins; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
  endtask

  initial begin
    rst_n = 1'b0; tbl = '0; idle1 = 1'b1; idle2 = 1'b1; sync_hold = 1'b0;
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    rst_n = 1'b1;
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_empty", 32'(queue_empty), 32'd1);
    check("reset_count", 32'(queue_count), 32'd0);

    // Basic dispatch to processor 1 one cycle after accept.
    set_req(1'b1, 32'hA5A5_0005, 5'd5, 5'd2, 5'd3);
    tick();
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    check("basic_no_early_pulse", 32'(boot1 | boot2), 32'd0);
    tick();
    check("basic_boot1", 32'(boot1), 32'd1);
    check("basic_rd", 32'(register_num), 32'd5);
    check("basic_instr", instr_out, 32'hA5A5_0005);
    check("basic_empty", 32'(queue_empty), 32'd1);
    repeat (3) tick();

    // Back-to-back: P1, blackout, P2, blackout, P1 once its guard expires.
    set_req(1'b1, 32'h0000_0404, 5'd4, 5'd0, 5'd0); tick();
    set_req(1'b1, 32'h0000_0606, 5'd6, 5'd0, 5'd0); tick();
    check("b2b_p1_rd4", 32'({boot1, boot2, register_num}), {25'd0, 2'b10, 5'd4});
    set_req(1'b1, 32'h0000_0707, 5'd7, 5'd0, 5'd0); tick();
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    check("b2b_blackout", 32'(boot1 | boot2), 32'd0);
    tick();
    check("b2b_p2_rd6", 32'({boot1, boot2, register_num}), {25'd0, 2'b01, 5'd6});
    tick(); tick();
    check("b2b_p1_rd7", 32'({boot1, boot2, register_num}), {25'd0, 2'b10, 5'd7});
    repeat (3) tick();

    // Hazard on rs1=6, then x0/ra sources are never blocking.
    tbl[6] = 1'b1;
    set_req(1'b1, 32'h0000_0909, 5'd9, 5'd6, 5'd0); tick();
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    check("hazard_stall", 32'({boot1 | boot2, queue_count}), {28'd0, 1'b0, 3'd1});
    tbl[6] = 1'b0;
    tick();
    check("hazard_release", 32'({boot1, register_num}), {26'd0, 1'b1, 5'd9});
    tbl[0] = 1'b1; tbl[1] = 1'b1;
    set_req(1'b1, 32'h0000_0A0A, 5'd10, 5'd0, 5'd1); tick();
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check("x0_ra_not_blocked", 32'({boot1 | boot2, register_num}), {26'd0, 1'b1, 5'd10});
    tbl = '0;
    repeat (3) tick();

    // Full queue with both processors busy.
    idle1 = 1'b0; idle2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h0000_1100 + 32'(i), 5'(11 + i), 5'd0, 5'd0);
      tick();
    end
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_count", 32'(queue_count), 32'd4);
    set_req(1'b1, 32'h0000_1515, 5'd15, 5'd0, 5'd0); tick();
    check("full_reject", 32'(queue_count), 32'd4);
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    idle1 = 1'b1;
    tick();
    check("full_pop", 32'({boot1, register_num, queue_count}), {23'd0, 1'b1, 5'd11, 3'd3});
    check("full_ready_back", 32'(req_ready), 32'd1);
    idle2 = 1'b1;
    repeat (10) tick();

    // sync_hold blocks a ready head without touching the queue.
    sync_hold = 1'b1;
    set_req(1'b1, 32'h0000_1414, 5'd20, 5'd0, 5'd0); tick();
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
    check("sync_hold_block", 32'({boot1 | boot2, queue_count}), {28'd0, 1'b0, 3'd1});
    sync_hold = 1'b0;
    tick();
    check("sync_release", 32'({boot1, register_num}), {26'd0, 1'b1, 5'd20});
    repeat (3) tick();

    // Reset with entries queued discards them.
    idle1 = 1'b0; idle2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h0000_2200 + 32'(i), 5'(22 + i), 5'd0, 5'd0);
      tick();
    end
    set_req(1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    idle1 = 1'b1; idle2 = 1'b1;
    rst_n = 1'b0; tick();
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_no_pulse", 32'(boot1 | boot2), 32'd0);
    rst_n = 1'b1; tick();
    check("rst_after", 32'({boot1 | boot2, queue_count}), 32'd0);

    // Random traffic with hazards, busy processors, holds and occasional reset.
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      sync_hold = ($urandom_range(0, 7) == 0);
      idle1     = ($urandom_range(0, 3) != 0);
      idle2     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        tbl = '0;
        for (int i = 0; i < 8; i++) tbl[i] = ($urandom_range(0, 3) == 0);
      end
      set_req(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
